// File: rtl/shiftleds_mode_ctrl.sv
// Front-panel controller producing the shiftleds config word from three debounced buttons.
// Optional run-transition counter (o_run_cnt) is built when SHIFTLEDS_CTRL_STATS_EN is defined.
module shiftleds_mode_ctrl #(
  parameter int unsigned NB_SW       = 4,
  parameter int unsigned NB_SEL      = 2,
  parameter int unsigned NB_DB       = 5,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned NB_STEP     = 14,
  parameter int unsigned STEP_CYCLES = 10000
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_btn_run,
  input  logic             i_btn_speed,
  input  logic             i_btn_mode,
  input  logic             i_auto,
  output logic [NB_SW-1:0] o_sw,
  output logic [1:0]       o_state
`ifdef SHIFTLEDS_CTRL_STATS_EN
  ,
  output logic [7:0]       o_run_cnt
`endif
);

  localparam int unsigned NB_BTN    = 3;
  localparam int unsigned BTN_RUN   = 0;
  localparam int unsigned BTN_SPEED = 1;
  localparam int unsigned BTN_MODE  = 2;

  localparam logic [NB_DB-1:0]   DB_LAST   = NB_DB'(DB_CYCLES - 1);
  localparam logic [NB_STEP-1:0] STEP_LAST = NB_STEP'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  // Button synchronise + debounce
  logic [NB_BTN-1:0]            btn_raw;
  logic [NB_BTN-1:0]            sync1_q, sync2_q;
  logic [NB_BTN-1:0]            stable_q, stable_d;
  logic [NB_BTN-1:0][NB_DB-1:0] db_cnt_q, db_cnt_d;
  logic [NB_BTN-1:0]            press_c;

  assign btn_raw = {i_btn_mode, i_btn_speed, i_btn_run};

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int b = 0; b < int'(NB_BTN); b++) begin
      if (sync2_q[b] != stable_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          stable_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + NB_DB'(1);
        end
      end
    end
  end

  // Pulse in the cycle the stable value rises, so the FSM reacts on the accepting edge
  assign press_c = stable_d & ~stable_q;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Mode FSM and config fields
  state_e              state_q, state_d;
  logic [NB_SEL-1:0]   sel_q, sel_d;
  logic                mode_q, mode_d;
  logic                en_q, en_d;
  logic [NB_STEP-1:0]  timer_q, timer_d;
  logic                soft_clr_c;
  logic                counting_c;
  logic                step_tick_c;
`ifdef SHIFTLEDS_CTRL_STATS_EN
  logic [7:0]          run_cnt_q, run_cnt_d;
`endif

  assign soft_clr_c  = press_c[BTN_SPEED] & press_c[BTN_MODE];
  assign counting_c  = (state_q == ST_RUN) && i_auto;
  assign step_tick_c = counting_c && (timer_q == STEP_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    timer_d = '0;
    en_d    = 1'b0;
`ifdef SHIFTLEDS_CTRL_STATS_EN
    run_cnt_d = run_cnt_q;
`endif

    case (state_q)
      ST_IDLE:  if (press_c[BTN_RUN]) state_d = ST_RUN;
      ST_RUN:   if (press_c[BTN_RUN]) state_d = ST_PAUSE;
      ST_PAUSE: if (press_c[BTN_RUN]) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (state_q == ST_ILLEGAL) begin
      sel_d  = '0;
      mode_d = 1'b0;
    end else begin
      // Manual press and timer terminal together still yield a single step
      if (press_c[BTN_SPEED] || step_tick_c) sel_d = sel_q + NB_SEL'(1);
      if (press_c[BTN_MODE]) mode_d = ~mode_q;
      if (counting_c && !step_tick_c && !press_c[BTN_SPEED] && (state_d == state_q)) begin
        timer_d = timer_q + NB_STEP'(1);
      end
    end

    if (soft_clr_c) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      mode_d  = 1'b0;
      timer_d = '0;
    end

    en_d = (state_d == ST_RUN);

`ifdef SHIFTLEDS_CTRL_STATS_EN
    if (soft_clr_c) begin
      run_cnt_d = '0;
    end else if ((state_q != ST_RUN) && (state_d == ST_RUN) && (run_cnt_q != 8'hFF)) begin
      run_cnt_d = run_cnt_q + 8'd1;
    end
`endif
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      timer_q <= timer_d;
    end
  end

`ifdef SHIFTLEDS_CTRL_STATS_EN
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign o_run_cnt = run_cnt_q;
`endif

  assign o_sw    = {mode_q, sel_q, en_q};
  assign o_state = state_q;

endmodule

// File: tb/tb_shiftleds_mode_ctrl.sv
// Directed bench for shiftleds_mode_ctrl with DB_CYCLES=4, STEP_CYCLES=8.
// Also checks o_run_cnt when built with SHIFTLEDS_CTRL_STATS_EN.
module tb_shiftleds_mode_ctrl;

  logic       clock = 1'b0;
  logic       i_reset;
  logic       i_btn_run, i_btn_speed, i_btn_mode, i_auto;
  logic [3:0] o_sw;
  logic [1:0] o_state;
`ifdef SHIFTLEDS_CTRL_STATS_EN
  logic [7:0] o_run_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  shiftleds_mode_ctrl #(
    .NB_SW(4), .NB_SEL(2), .NB_DB(5), .DB_CYCLES(4), .NB_STEP(14), .STEP_CYCLES(8)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_btn_run  (i_btn_run),
    .i_btn_speed(i_btn_speed),
    .i_btn_mode (i_btn_mode),
    .i_auto     (i_auto),
    .o_sw       (o_sw),
    .o_state    (o_state)
`ifdef SHIFTLEDS_CTRL_STATS_EN
    ,
    .o_run_cnt  (o_run_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Raw edge to output update is 2 + DB_CYCLES = 6 clocks
  task automatic hold(input logic r, input logic s, input logic m);
    i_btn_run   = r;
    i_btn_speed = s;
    i_btn_mode  = m;
    tick(6);
  endtask

  task automatic rel();
    i_btn_run   = 1'b0;
    i_btn_speed = 1'b0;
    i_btn_mode  = 1'b0;
    tick(8);
  endtask

  logic [3:0] wrap_exp [4];

  initial begin
    wrap_exp = '{4'b0011, 4'b0101, 4'b0111, 4'b0001};
    i_reset = 1'b1;
    i_btn_run = 1'b0; i_btn_speed = 1'b0; i_btn_mode = 1'b0; i_auto = 1'b0;
    #1 i_reset = 1'b0;
    tick(2);
    chk("rst_sw", 8'(o_sw), 8'h00);
    chk("rst_state", 8'(o_state), 8'h00);
    i_reset = 1'b1;
    tick(2);

    // Bouncing run button: no event until held high long enough
    for (int i = 0; i < 10; i++) begin
      i_btn_run = (i % 2 == 0);
      tick(2);
    end
    chk("bounce_idle", 8'(o_state), 8'h00);
    i_btn_run = 1'b1;
    tick(5);
    chk("bounce_pre", 8'(o_state), 8'h00);
    tick(1);
    chk("bounce_run", 8'(o_state), 8'h01);
    chk("bounce_sw", 8'(o_sw), 8'h01);
    rel();
    chk("run_release", 8'(o_state), 8'h01);

    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 1'b1, 1'b0);
      chk($sformatf("wrap%0d", i), 8'(o_sw), 8'(wrap_exp[i]));
      rel();
    end

    // Pause with sel=2, mode=1
    hold(1'b0, 1'b1, 1'b0); rel();
    hold(1'b0, 1'b1, 1'b0); rel();
    hold(1'b0, 1'b0, 1'b1);
    chk("mode_sw", 8'(o_sw), 8'b1101);
    rel();
    hold(1'b1, 1'b0, 1'b0);
    chk("pause_sw", 8'(o_sw), 8'b1100);
    chk("pause_state", 8'(o_state), 8'h02);
    rel();
    hold(1'b1, 1'b0, 1'b0);
    chk("resume_sw", 8'(o_sw), 8'b1101);
    chk("resume_state", 8'(o_state), 8'h01);
    rel();
`ifdef SHIFTLEDS_CTRL_STATS_EN
    chk("run_cnt2", o_run_cnt, 8'd2);
`endif

    // Auto-step from sel=3
    hold(1'b0, 1'b1, 1'b0);
    chk("auto_pre", 8'(o_sw), 8'b1111);
    rel();
    i_auto = 1'b1;
    tick(7);
    chk("auto_7", 8'(o_sw), 8'b1111);
    tick(1);
    chk("auto_8", 8'(o_sw), 8'b1001);
    tick(8);
    chk("auto_16", 8'(o_sw), 8'b1011);
    tick(2);
    i_btn_speed = 1'b1;
    tick(5);
    chk("auto_23", 8'(o_sw), 8'b1011);
    tick(1);
    chk("auto_coinc", 8'(o_sw), 8'b1101);
    i_auto = 1'b0;
    rel();
    chk("auto_off", 8'(o_sw), 8'b1101);

    // Soft clear
    hold(1'b0, 1'b1, 1'b1);
    chk("sclr_state", 8'(o_state), 8'h00);
    chk("sclr_sw", 8'(o_sw), 8'h00);
`ifdef SHIFTLEDS_CTRL_STATS_EN
    chk("sclr_cnt", o_run_cnt, 8'd0);
`endif
    rel();

    // Asynchronous reset mid-RUN
    hold(1'b1, 1'b0, 1'b0);
    chk("rerun_state", 8'(o_state), 8'h01);
    rel();
`ifdef SHIFTLEDS_CTRL_STATS_EN
    chk("run_cnt1", o_run_cnt, 8'd1);
`endif
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 1'b1, 1'b0);
      rel();
    end
    chk("pre_rst_sw", 8'(o_sw), 8'b0111);
    i_reset = 1'b0;
    #2;
    chk("async_rst_sw", 8'(o_sw), 8'h00);
    chk("async_rst_state", 8'(o_state), 8'h00);
    tick(1);
    i_reset = 1'b1;
    tick(2);
    chk("post_rst_sw", 8'(o_sw), 8'h00);
    chk("post_rst_state", 8'(o_state), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
